// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO control blocks: state encoding, ID width
// and the round-robin search mask.
package fifo_ctrl_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Bits strictly above ptr are set: candidates that come after the last winner.
    function automatic logic [MAX_REQ-1:0] rr_mask_above(input int ptr);
        logic [MAX_REQ-1:0] m;
        for (int i = 0; i < MAX_REQ; i++) begin
            m[i] = (i > ptr);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams plus FIFO write port, seen from the arbiter (slave)
// and from the requesters/FIFO side (master).
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_W       = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH+ID_W-1:0]    fifo_din;
    logic                          fifo_full;

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din
    );

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid index above rr_ptr,
// wrapping to the lowest valid index.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    id
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] masked;
    logic [MAX_REQ-1:0] search;
    int                 sel;

    always_comb begin
        valid_ext = MAX_REQ'(valid);
        masked    = valid_ext & rr_mask_above(int'(rr_ptr));
        search    = (|masked) ? masked : valid_ext;
        sel       = 0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (search[i]) sel = i;
        end
        found = |valid;
        id    = ID_W'(sel);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing the FIFO write port among
// NUM_REQ requesters; beats are tagged with the source ID.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8,
    localparam int ID_W        = id_width(NUM_REQ)
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    fifo_wr_arbiter_if.slave   bus,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout_evt
);

    localparam int BEAT_W = $clog2(MAX_BURST) + 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t           state_reg;
    logic [ID_W-1:0]      grant_id_reg;
    logic [ID_W-1:0]      rr_ptr_reg;
    logic [BEAT_W-1:0]    beat_cnt_reg;
    logic [IDLE_W-1:0]    idle_cnt_reg;
    logic                 timeout_evt_reg;

    logic                 pick_found;
    logic [ID_W-1:0]      pick_id;
    logic [NUM_REQ-1:0]   gsel;
    logic [DATA_WIDTH-1:0] data_term [NUM_REQ];
    logic [DATA_WIDTH-1:0] grant_data;
    logic                 valid_g;
    logic                 last_g;
    logic                 accept;
    logic [BEAT_W-1:0]    beat_inc;
    logic [IDLE_W-1:0]    idle_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid  (bus.req_valid),
        .rr_ptr (rr_ptr_reg),
        .found  (pick_found),
        .id     (pick_id)
    );

    // One-hot grant select, empty outside BURST so nothing leaks through.
    assign gsel = (state_reg == BURST) ? (NUM_REQ'(1) << grant_id_reg) : '0;

    // AND-OR mux: unknown payloads on non-granted lanes are forced to zero.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign data_term[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                   & {DATA_WIDTH{gsel[gi]}};
        end
    endgenerate

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_data = grant_data | data_term[i];
        end
    end

    assign valid_g = |(bus.req_valid & gsel);
    assign last_g  = |(bus.req_last & gsel);
    assign accept  = valid_g & ~bus.fifo_full;

    assign bus.req_ready  = gsel & {NUM_REQ{~bus.fifo_full}};
    assign bus.fifo_wr_en = accept;
    assign bus.fifo_din   = {grant_id_reg, grant_data};

    assign beat_inc = beat_cnt_reg + BEAT_W'(1);
    assign idle_inc = idle_cnt_reg + IDLE_W'(1);

    assign grant_id    = grant_id_reg;
    assign busy        = (state_reg == BURST);
    assign timeout_evt = timeout_evt_reg;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_reg       <= ARB;
            rr_ptr_reg      <= ID_W'(NUM_REQ - 1);
            grant_id_reg    <= '0;
            beat_cnt_reg    <= '0;
            idle_cnt_reg    <= '0;
            timeout_evt_reg <= 1'b0;
        end else begin
            timeout_evt_reg <= 1'b0;
            case (state_reg)
                ARB: begin
                    if (pick_found) begin
                        grant_id_reg <= pick_id;
                        rr_ptr_reg   <= pick_id;
                        beat_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                        state_reg    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt_reg <= beat_inc;
                        idle_cnt_reg <= '0;
                        if (last_g || (beat_inc == BEAT_W'(MAX_BURST))) begin
                            state_reg <= ARB;
                        end
                    end else if (!valid_g && !bus.fifo_full) begin
                        // Only requester silence counts; back-pressure holds the count.
                        if (idle_inc >= IDLE_W'(IDLE_TIMEOUT)) begin
                            idle_cnt_reg    <= IDLE_W'(IDLE_TIMEOUT);
                            state_reg       <= ARB;
                            timeout_evt_reg <= 1'b1;
                        end else begin
                            idle_cnt_reg <= idle_inc;
                        end
                    end
                end
            endcase
        end
    end

endmodule
